// File: rtl/piso_ctrl_pkg.sv
// Shared types and helpers for the round-robin PISO transmit controller.
// Holds the FSM state type and the wrap-around pointer step used by the arbiter.
package piso_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Next round-robin position after idx, wrapping modulo n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register, MSB first, zero fill.
// A load on the same edge as a shift wins so back-to-back frames need no gap.
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             y
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= d;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign y = sr[WIDTH-1];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter feeding one shared serializer; each accepted word is
// shifted out MSB first and tagged with the index of the requester that sent it.
module piso_tx_arbiter
  import piso_ctrl_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 4,
  localparam int SRCW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic [SRCW-1:0]       ser_src,
  output logic                  busy
);

  localparam int              CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [SRCW-1:0]   ptr;
  logic [SRCW-1:0]   gnt_idx;
  logic [SRCW:0]     cand;
  logic              gnt_found;
  logic              window_open;
  logic              accept;
  logic [WIDTH-1:0]  gnt_word;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + (SRCW+1)'(i);
      if (cand >= (SRCW+1)'(NREQ)) cand = cand - (SRCW+1)'(NREQ);
      if (!gnt_found && req_valid[cand[SRCW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[SRCW-1:0];
      end
    end
  end

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (SRCW'(i) == gnt_idx) gnt_word = req_data[i*WIDTH +: WIDTH];
    end
  end

  // The window reopens on the last bit so the next word can load with no idle gap.
  assign window_open = rst && ((state == IDLE) || (cnt == LAST));
  assign accept      = window_open && gnt_found;
  assign req_ready   = accept ? (NREQ'(1) << gnt_idx) : '0;
  assign busy        = ser_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      ser_src   <= '0;
      ser_valid <= 1'b0;
    end else if (accept) begin
      state     <= SHIFT;
      cnt       <= '0;
      ser_src   <= gnt_idx;
      ptr       <= SRCW'(rr_next(32'(gnt_idx), NREQ));
      ser_valid <= 1'b1;
    end else if (state == SHIFT) begin
      if (cnt == LAST) begin
        state     <= IDLE;
        cnt       <= '0;
        ser_valid <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(state == SHIFT),
    .d    (gnt_word),
    .y    (ser_out)
  );

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench for piso_tx_arbiter: a queue-based frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_piso_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int SRCW  = $clog2(NREQ);

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  ser_out;
  logic                  ser_valid;
  logic [SRCW-1:0]       ser_src;
  logic                  busy;

  int checks;
  int failures;

  bit mq[$];
  int msrc;
  int mptr;

  int glog[$];
  bit blog[$];
  int readycycles;
  int run;
  int maxrun;

  piso_tx_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_src  (ser_src),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearModel();
    mq.delete();
    msrc = 0;
    mptr = 0;
  endtask

  // A frame is a queue of pending bits; the grant window is open when at most the last bit remains.
  function automatic int modelWinner();
    int idx;
    if (mq.size() > 1) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (mptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic compareModel();
    int w;
    logic [NREQ-1:0] expready;
    logic expvalid;
    logic expout;
    int expsrc;
    expready = '0;
    expvalid = 1'b0;
    expout   = 1'b0;
    expsrc   = 0;
    if (rst) begin
      w = modelWinner();
      if (w >= 0) expready = NREQ'(1) << w;
      expvalid = (mq.size() > 0);
      expout   = expvalid ? mq[0] : 1'b0;
      expsrc   = msrc;
    end
    checkOutput("req_ready", 32'(req_ready), 32'(expready));
    checkOutput("ser_valid", 32'(ser_valid), 32'(expvalid));
    checkOutput("ser_out", 32'(ser_out), 32'(expout));
    checkOutput("ser_src", 32'(ser_src), 32'(expsrc));
    checkOutput("busy", 32'(busy), 32'(expvalid));
  endtask

  task automatic updateModel();
    int w;
    logic [WIDTH-1:0] word;
    if (!rst) begin
      clearModel();
    end else begin
      w = modelWinner();
      if (w >= 0) begin
        word = req_data[w*WIDTH +: WIDTH];
        mq.delete();
        for (int b = WIDTH - 1; b >= 0; b--) mq.push_back(word[b]);
        msrc = w;
        mptr = (w + 1) % NREQ;
      end else if (mq.size() > 0) begin
        void'(mq.pop_front());
      end
    end
  endtask

  task automatic clearLogs();
    glog.delete();
    blog.delete();
    readycycles = 0;
    run = 0;
    maxrun = 0;
  endtask

  function automatic int packBits();
    int v;
    v = 0;
    foreach (blog[i]) v = (v << 1) | int'(blog[i]);
    return v;
  endfunction

  function automatic int packGrants();
    int v;
    v = 0;
    foreach (glog[i]) v = (v << 4) | glog[i];
    return v;
  endfunction

  // One clock: compare at the falling edge, advance the model on the rising edge,
  // then retire any requester whose word was just accepted.
  task automatic applyStimulus();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    compareModel();
    acc = req_valid & req_ready;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) if (acc[i]) glog.push_back(i);
    end
    if (req_ready != '0) readycycles++;
    if (ser_valid) begin
      blog.push_back(ser_out);
      run++;
      if (run > maxrun) maxrun = run;
    end else begin
      run = 0;
    end
    @(posedge clk);
    updateModel();
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic applyReset();
    req_valid = '0;
    rst = 1'b0;
    clearModel();
    repeat (2) applyStimulus();
    rst = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    clearModel();
    clearLogs();

    repeat (3) applyStimulus();
    checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_ser_out", 32'(ser_out), 32'h0);
    checkOutput("reset_ser_valid", 32'(ser_valid), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_ser_src", 32'(ser_src), 32'h0);
    req_valid = '0;
    rst = 1'b1;

    req_data  = 16'h0007;
    req_valid = 4'b0001;
    clearLogs();
    repeat (8) applyStimulus();
    checkOutput("single_grants", 32'(glog.size()), 32'd1);
    checkOutput("single_ready_cycles", 32'(readycycles), 32'd1);
    checkOutput("single_bits", 32'(packBits()), 32'h7);
    checkOutput("single_bitcount", 32'(blog.size()), 32'd4);
    checkOutput("single_idle", 32'(ser_valid), 32'h0);

    applyReset();
    req_data  = 16'h1248;
    req_valid = 4'b1111;
    clearLogs();
    repeat (20) applyStimulus();
    checkOutput("b2b_grant_order", 32'(packGrants()), 32'h0123);
    checkOutput("b2b_grant_count", 32'(glog.size()), 32'd4);
    checkOutput("b2b_stream", 32'(packBits()), 32'h8421);
    checkOutput("b2b_valid_run", 32'(maxrun), 32'd16);

    applyReset();
    req_data  = 16'h0C00;
    req_valid = 4'b0100;
    clearLogs();
    applyStimulus();
    req_data  = 16'h9C05;
    req_valid = req_valid | 4'b1001;
    repeat (14) applyStimulus();
    checkOutput("fair_grant_order", 32'(packGrants()), 32'h230);
    checkOutput("fair_stream", 32'(packBits()), 32'hC95);

    applyReset();
    req_data  = 16'h000F;
    req_valid = 4'b0001;
    clearLogs();
    repeat (3) applyStimulus();
    rst = 1'b0;
    clearModel();
    #1;
    checkOutput("midreset_ser_valid", 32'(ser_valid), 32'h0);
    checkOutput("midreset_ser_out", 32'(ser_out), 32'h0);
    checkOutput("midreset_busy", 32'(busy), 32'h0);
    checkOutput("midreset_bits_before", 32'(packBits()), 32'h3);
    req_data  = 16'h600A;
    req_valid = 4'b1001;
    repeat (2) applyStimulus();
    rst = 1'b1;
    clearLogs();
    repeat (12) applyStimulus();
    checkOutput("midreset_grant_order", 32'(packGrants()), 32'h03);
    checkOutput("midreset_stream", 32'(packBits()), 32'hA6);

    applyReset();
    req_data  = 16'h005A;
    req_valid = 4'b0001;
    clearLogs();
    applyStimulus();
    req_valid[1] = 1'b1;
    applyStimulus();
    req_valid[1] = 1'b0;
    repeat (8) applyStimulus();
    checkOutput("withdraw_grant_count", 32'(glog.size()), 32'd1);
    checkOutput("withdraw_grants", 32'(packGrants()), 32'h0);
    checkOutput("withdraw_stream", 32'(packBits()), 32'hA);
    checkOutput("withdraw_bitcount", 32'(blog.size()), 32'd4);
    checkOutput("withdraw_idle", 32'(ser_valid), 32'h0);

    applyReset();
    clearLogs();
    repeat (1500) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        clearModel();
        repeat (2) applyStimulus();
        rst = 1'b1;
      end
      applyStimulus();
    end
    req_valid = '0;
    repeat (2 * WIDTH) applyStimulus();
    checkOutput("rand_traffic_seen", 32'(glog.size() > 50), 32'h1);
    checkOutput("rand_drained", 32'(ser_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
